// File: rtl/control_unit.sv
// Multi-cycle control unit: FETCH/DECODE/EXECUTE/MEM/WB sequencer that owns the PC and IR
// and drives ALU, register-file and data-memory control for a 16-bit ISA.
module control_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] INSTR,
    input  logic        FLAG,
    output logic [15:0] PC,
    output logic [2:0]  ALU_CTRL,
    output logic        ALU_SRC_IMM,
    output logic [15:0] IMM,
    output logic [2:0]  RF_RADDR1,
    output logic [2:0]  RF_RADDR2,
    output logic [2:0]  RF_WADDR,
    output logic        RF_WE,
    output logic        WB_SEL,
    output logic        MEM_RE,
    output logic        MEM_WE,
    output logic        HALTED
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_ADDI  = 4'd8;
    localparam logic [3:0] OP_LOAD  = 4'd9;
    localparam logic [3:0] OP_STORE = 4'd10;
    localparam logic [3:0] OP_BEQ   = 4'd11;
    localparam logic [3:0] OP_JMP   = 4'd12;
    localparam logic [3:0] OP_HALT  = 4'd15;

    typedef struct packed {
        logic [2:0]  alu_ctrl;
        logic        alu_src_imm;
        logic        wb_sel;
        logic [15:0] imm;
        logic [2:0]  raddr1;
        logic [2:0]  raddr2;
        logic [2:0]  waddr;
    } dec_t;

    state_t      state, state_nxt;
    logic [15:0] pc, pc_nxt;
    logic [15:0] ir;
    logic [3:0]  op;
    dec_t        dec;
    logic        rf_we, mem_re, mem_we;

    assign op = ir[15:12];

    // Decode is a pure function of IR, so fields are valid from DECODE until the next
    // FETCH edge, and an all-zero IR after reset yields all-zero controls.
    always_comb begin
        dec             = '0;
        dec.imm         = {{10{ir[5]}}, ir[5:0]};
        dec.raddr1      = ir[8:6];
        dec.raddr2      = ir[5:3];
        dec.waddr       = ir[11:9];
        if (!op[3]) begin
            dec.alu_ctrl = op[2:0];
        end else begin
            case (op)
                OP_ADDI:  dec.alu_src_imm = 1'b1;
                OP_LOAD: begin
                    dec.alu_src_imm = 1'b1;
                    dec.wb_sel      = 1'b1;
                end
                OP_STORE: begin
                    dec.alu_src_imm = 1'b1;
                    dec.raddr2      = ir[11:9];
                end
                OP_BEQ: begin
                    dec.alu_ctrl = 3'd1;
                    dec.raddr2   = ir[11:9];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            ir    <= 16'h0000;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (state == S_FETCH)
                ir <= INSTR;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        rf_we     = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        case (state)
            S_FETCH: begin
                pc_nxt    = pc + 16'd1;
                state_nxt = S_DECODE;
            end
            S_DECODE: state_nxt = (op == OP_HALT) ? S_HALT : S_EXEC;
            S_EXEC: begin
                state_nxt = S_FETCH;
                if (!op[3] || op == OP_ADDI)
                    state_nxt = S_WB;
                else if (op == OP_LOAD || op == OP_STORE)
                    state_nxt = S_MEM;
                else if (op == OP_BEQ && FLAG)
                    pc_nxt = pc + dec.imm;  // pc already points past the branch
                else if (op == OP_JMP)
                    pc_nxt = {4'h0, ir[11:0]};
            end
            S_MEM: begin
                if (op == OP_LOAD) begin
                    mem_re    = 1'b1;
                    state_nxt = S_WB;
                end else begin
                    mem_we    = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_WB: begin
                rf_we     = 1'b1;
                state_nxt = S_FETCH;
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
    end

    // Reset kills strobes in the same cycle so an aborted instruction never writes.
    assign RF_WE       = rf_we & ~RST;
    assign MEM_RE      = mem_re & ~RST;
    assign MEM_WE      = mem_we & ~RST;
    assign PC          = pc;
    assign HALTED      = (state == S_HALT);
    assign ALU_CTRL    = dec.alu_ctrl;
    assign ALU_SRC_IMM = dec.alu_src_imm;
    assign IMM         = dec.imm;
    assign RF_RADDR1   = dec.raddr1;
    assign RF_RADDR2   = dec.raddr2;
    assign RF_WADDR    = dec.waddr;
    assign WB_SEL      = dec.wb_sel;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-instruction latency, decode fields, strobes,
// branch/jump PC arithmetic, halt and reset behaviour.
module tb_control_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] INSTR = 16'h0000;
    logic        FLAG = 1'b0;
    logic [15:0] PC;
    logic [2:0]  ALU_CTRL;
    logic        ALU_SRC_IMM;
    logic [15:0] IMM;
    logic [2:0]  RF_RADDR1, RF_RADDR2, RF_WADDR;
    logic        RF_WE, WB_SEL, MEM_RE, MEM_WE, HALTED;

    int n_cmp = 0;
    int n_bad = 0;

    control_unit #(.RESET_PC(16'h0000)) dut (
        .CLK(CLK), .RST(RST), .INSTR(INSTR), .FLAG(FLAG), .PC(PC),
        .ALU_CTRL(ALU_CTRL), .ALU_SRC_IMM(ALU_SRC_IMM), .IMM(IMM),
        .RF_RADDR1(RF_RADDR1), .RF_RADDR2(RF_RADDR2), .RF_WADDR(RF_WADDR),
        .RF_WE(RF_WE), .WB_SEL(WB_SEL), .MEM_RE(MEM_RE), .MEM_WE(MEM_WE),
        .HALTED(HALTED)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    // Advance one cycle; outputs are then observed 1ns after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step();
        step();
        n_cmp++;
        if (PC !== 16'h0000 || HALTED !== 1'b0) begin
            n_bad++; $display("FAIL reset_pc: PC=%h HALTED=%b, want 0000/0", PC, HALTED);
        end
        n_cmp++;
        if ({RF_WE, MEM_RE, MEM_WE} !== 3'b000) begin
            n_bad++; $display("FAIL reset_strobes: got %b want 000", {RF_WE, MEM_RE, MEM_WE});
        end
        n_cmp++;
        if ({ALU_CTRL, ALU_SRC_IMM, IMM, RF_RADDR1, RF_RADDR2, RF_WADDR, WB_SEL} !== 30'h0) begin
            n_bad++; $display("FAIL reset_ctrl: ctrl=%h src=%b imm=%h ra1=%0d ra2=%0d wa=%0d wb=%b, want all 0",
                              ALU_CTRL, ALU_SRC_IMM, IMM, RF_RADDR1, RF_RADDR2, RF_WADDR, WB_SEL);
        end
        RST = 1'b0;
    endtask

    // ADD R1 = R2 + R3 at PC 0: write-back only in cycle 4.
    task automatic test_add();
        logic [3:0] we_seen;
        INSTR = 16'h0298;
        we_seen[0] = RF_WE;              // cycle 1 (FETCH)
        step(); we_seen[1] = RF_WE;      // cycle 2 (DECODE)
        n_cmp++;
        if (PC !== 16'h0001 || ALU_CTRL !== 3'd0 || ALU_SRC_IMM !== 1'b0 ||
            RF_RADDR1 !== 3'd2 || RF_RADDR2 !== 3'd3 || RF_WADDR !== 3'd1) begin
            n_bad++; $display("FAIL add_decode: PC=%h ctrl=%0d src=%b ra1=%0d ra2=%0d wa=%0d, want 0001/0/0/2/3/1",
                              PC, ALU_CTRL, ALU_SRC_IMM, RF_RADDR1, RF_RADDR2, RF_WADDR);
        end
        step(); we_seen[2] = RF_WE;      // cycle 3 (EXECUTE)
        step(); we_seen[3] = RF_WE;      // cycle 4 (WB)
        n_cmp++;
        if (we_seen !== 4'b1000 || WB_SEL !== 1'b0 || RF_WADDR !== 3'd1 || MEM_RE !== 1'b0 || MEM_WE !== 1'b0) begin
            n_bad++; $display("FAIL add_wb: rf_we by cycle=%b wb_sel=%b wa=%0d, want 1000/0/1", we_seen, WB_SEL, RF_WADDR);
        end
        step();
        n_cmp++;
        if (PC !== 16'h0001 || RF_WE !== 1'b0) begin
            n_bad++; $display("FAIL add_next: PC=%h RF_WE=%b, want 0001/0", PC, RF_WE);
        end
    endtask

    // LOAD R2 = MEM[R1 - 1] at PC 1.
    task automatic test_load();
        logic [4:0] re_seen, we_seen;
        INSTR = 16'h947F;
        re_seen[0] = MEM_RE; we_seen[0] = RF_WE;
        step(); re_seen[1] = MEM_RE; we_seen[1] = RF_WE;
        n_cmp++;
        if (IMM !== 16'hFFFF || ALU_SRC_IMM !== 1'b1 || ALU_CTRL !== 3'd0 || RF_RADDR1 !== 3'd1) begin
            n_bad++; $display("FAIL load_decode: imm=%h src=%b ctrl=%0d ra1=%0d, want FFFF/1/0/1",
                              IMM, ALU_SRC_IMM, ALU_CTRL, RF_RADDR1);
        end
        step(); re_seen[2] = MEM_RE; we_seen[2] = RF_WE;
        step(); re_seen[3] = MEM_RE; we_seen[3] = RF_WE;
        step(); re_seen[4] = MEM_RE; we_seen[4] = RF_WE;
        n_cmp++;
        if (re_seen !== 5'b01000 || we_seen !== 5'b10000 || WB_SEL !== 1'b1 || RF_WADDR !== 3'd2 || MEM_WE !== 1'b0) begin
            n_bad++; $display("FAIL load_seq: mem_re=%b rf_we=%b wb_sel=%b wa=%0d, want 01000/10000/1/2",
                              re_seen, we_seen, WB_SEL, RF_WADDR);
        end
        step();
        n_cmp++;
        if (PC !== 16'h0002 || RF_WE !== 1'b0) begin
            n_bad++; $display("FAIL load_next: PC=%h RF_WE=%b, want 0002/0", PC, RF_WE);
        end
    endtask

    // STORE MEM[R4 + 5] = R3 at PC 2.
    task automatic test_store();
        logic [3:0] mw_seen, other;
        INSTR = 16'hA705;
        mw_seen[0] = MEM_WE; other[0] = RF_WE | MEM_RE;
        step(); mw_seen[1] = MEM_WE; other[1] = RF_WE | MEM_RE;
        n_cmp++;
        if (RF_RADDR1 !== 3'd4 || RF_RADDR2 !== 3'd3 || IMM !== 16'h0005 || ALU_SRC_IMM !== 1'b1) begin
            n_bad++; $display("FAIL store_decode: ra1=%0d ra2=%0d imm=%h src=%b, want 4/3/0005/1",
                              RF_RADDR1, RF_RADDR2, IMM, ALU_SRC_IMM);
        end
        step(); mw_seen[2] = MEM_WE; other[2] = RF_WE | MEM_RE;
        step(); mw_seen[3] = MEM_WE; other[3] = RF_WE | MEM_RE;
        n_cmp++;
        if (mw_seen !== 4'b1000 || other !== 4'b0000) begin
            n_bad++; $display("FAIL store_seq: mem_we=%b other=%b, want 1000/0000", mw_seen, other);
        end
        step();
        n_cmp++;
        if (PC !== 16'h0003 || MEM_WE !== 1'b0) begin
            n_bad++; $display("FAIL store_next: PC=%h MEM_WE=%b, want 0003/0", PC, MEM_WE);
        end
    endtask

    // JMP 0xABC from PC 3: three cycles, upper nibble forced to zero.
    task automatic test_jmp();
        logic any_strobe;
        INSTR = 16'hCABC;
        any_strobe = RF_WE | MEM_RE | MEM_WE;
        for (int i = 0; i < 3; i++) begin
            step();
            any_strobe |= RF_WE | MEM_RE | MEM_WE;
        end
        n_cmp++;
        if (PC !== 16'h0ABC || any_strobe !== 1'b0) begin
            n_bad++; $display("FAIL jmp: PC=%h strobe=%b, want 0ABC/0", PC, any_strobe);
        end
    endtask

    // Run a 3-cycle BEQ with FLAG high outside EXECUTE and `flag_exec` inside it.
    task automatic run_beq(input logic [15:0] ins, input logic flag_exec, output logic strobe);
        INSTR = ins;
        FLAG = 1'b1;
        strobe = RF_WE | MEM_RE | MEM_WE;
        step(); strobe |= RF_WE | MEM_RE | MEM_WE;
        FLAG = flag_exec;
        step(); strobe |= RF_WE | MEM_RE | MEM_WE;
        step(); strobe |= RF_WE | MEM_RE | MEM_WE;
        FLAG = 1'b1;
    endtask

    task automatic test_beq();
        logic s;
        INSTR = 16'hC010;
        repeat (3) step();
        run_beq(16'hB2BE, 1'b1, s);
        n_cmp++;
        if (PC !== 16'h000F || s !== 1'b0) begin
            n_bad++; $display("FAIL beq_taken: PC=%h strobe=%b, want 000F/0", PC, s);
        end
        INSTR = 16'hC010;
        repeat (3) step();
        INSTR = 16'hB2BE;
        step();
        n_cmp++;
        if (RF_RADDR1 !== 3'd2 || RF_RADDR2 !== 3'd1 || ALU_CTRL !== 3'd1 || IMM !== 16'hFFFE) begin
            n_bad++; $display("FAIL beq_decode: ra1=%0d ra2=%0d ctrl=%0d imm=%h, want 2/1/1/FFFE",
                              RF_RADDR1, RF_RADDR2, ALU_CTRL, IMM);
        end
        FLAG = 1'b0;
        repeat (2) step();
        FLAG = 1'b0;
        n_cmp++;
        if (PC !== 16'h0011) begin
            n_bad++; $display("FAIL beq_not_taken: PC=%h, want 0011", PC);
        end
    endtask

    // Branch back from PC 0 to 0xFFFF, then a NOP fetch there wraps the PC to 0.
    task automatic test_wrap();
        logic s;
        do_reset();
        run_beq(16'hB2BE, 1'b1, s);
        n_cmp++;
        if (PC !== 16'hFFFF) begin
            n_bad++; $display("FAIL wrap_setup: PC=%h, want FFFF", PC);
        end
        INSTR = 16'hD000;
        FLAG = 1'b0;
        s = 1'b0;
        step(); s |= RF_WE | MEM_RE | MEM_WE;
        n_cmp++;
        if (PC !== 16'h0000) begin
            n_bad++; $display("FAIL wrap_pc: PC=%h, want 0000", PC);
        end
        step(); s |= RF_WE | MEM_RE | MEM_WE;
        step(); s |= RF_WE | MEM_RE | MEM_WE;
        n_cmp++;
        if (PC !== 16'h0000 || s !== 1'b0) begin
            n_bad++; $display("FAIL nop: PC=%h strobe=%b, want 0000/0", PC, s);
        end
    endtask

    // ADDI then R-type GT back to back from PC 0.
    task automatic test_back_to_back();
        INSTR = 16'h8B9F;
        step();
        n_cmp++;
        if (ALU_SRC_IMM !== 1'b1 || ALU_CTRL !== 3'd0 || IMM !== 16'h001F || RF_RADDR1 !== 3'd6) begin
            n_bad++; $display("FAIL addi_decode: src=%b ctrl=%0d imm=%h ra1=%0d, want 1/0/001F/6",
                              ALU_SRC_IMM, ALU_CTRL, IMM, RF_RADDR1);
        end
        step(); step();
        n_cmp++;
        if (RF_WE !== 1'b1 || RF_WADDR !== 3'd5 || WB_SEL !== 1'b0) begin
            n_bad++; $display("FAIL addi_wb: rf_we=%b wa=%0d wb_sel=%b, want 1/5/0", RF_WE, RF_WADDR, WB_SEL);
        end
        INSTR = 16'h7E50;
        step(); step();
        n_cmp++;
        if (PC !== 16'h0002 || ALU_CTRL !== 3'd7 || ALU_SRC_IMM !== 1'b0 || RF_RADDR2 !== 3'd2) begin
            n_bad++; $display("FAIL gt_decode: PC=%h ctrl=%0d src=%b ra2=%0d, want 0002/7/0/2",
                              PC, ALU_CTRL, ALU_SRC_IMM, RF_RADDR2);
        end
        step(); step();
        n_cmp++;
        if (RF_WE !== 1'b1 || RF_WADDR !== 3'd7) begin
            n_bad++; $display("FAIL gt_wb: rf_we=%b wa=%0d, want 1/7", RF_WE, RF_WADDR);
        end
        step();
    endtask

    task automatic test_halt();
        logic bad;
        INSTR = 16'hF000;
        step();
        n_cmp++;
        if (HALTED !== 1'b0) begin
            n_bad++; $display("FAIL halt_decode: HALTED=%b in DECODE, want 0", HALTED);
        end
        INSTR = 16'h0298;
        step();
        n_cmp++;
        if (HALTED !== 1'b1 || PC !== 16'h0003) begin
            n_bad++; $display("FAIL halt_enter: HALTED=%b PC=%h, want 1/0003", HALTED, PC);
        end
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            FLAG = ~FLAG;
            if (HALTED !== 1'b1 || PC !== 16'h0003 || (RF_WE | MEM_RE | MEM_WE) !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad !== 1'b0) begin
            n_bad++; $display("FAIL halt_hold: deviation seen, last HALTED=%b PC=%h", HALTED, PC);
        end
        do_reset();
        n_cmp++;
        if (PC !== 16'h0000 || HALTED !== 1'b0) begin
            n_bad++; $display("FAIL halt_reset: PC=%h HALTED=%b, want 0000/0", PC, HALTED);
        end
    endtask

    // Reset in WB of an ADD: no write that cycle, restart at FETCH from RESET_PC.
    task automatic test_reset_in_wb();
        INSTR = 16'h0298;
        repeat (3) step();
        RST = 1'b1;
        #1;
        n_cmp++;
        if (RF_WE !== 1'b0) begin
            n_bad++; $display("FAIL rst_wb_we: RF_WE=%b, want 0", RF_WE);
        end
        step();
        RST = 1'b0;
        n_cmp++;
        if (PC !== 16'h0000 || RF_WE !== 1'b0 || HALTED !== 1'b0) begin
            n_bad++; $display("FAIL rst_wb_state: PC=%h RF_WE=%b HALTED=%b, want 0000/0/0", PC, RF_WE, HALTED);
        end
        step();
        n_cmp++;
        if (PC !== 16'h0001) begin
            n_bad++; $display("FAIL rst_wb_fetch: PC=%h, want 0001", PC);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_load();
        test_store();
        test_jmp();
        test_beq();
        test_wrap();
        test_back_to_back();
        test_halt();
        test_reset_in_wb();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
